audio_frame_scheduler: RTL and testbench
========================================

Name: audio_frame_scheduler

Overview:
- Sequences one stereo frame at a time between the Audio_Controller FIFOs and a single shared pitch-shift engine.
- Pops one L/R sample pair, time-multiplexes the engine (left, then right), then pushes the processed pair to the DAC FIFO.
- Replaces the free-running read/write strobes and the duplicated per-channel engines at top level; one engine instance serves both channels.

Parameters:
- DATA_W, 32, sample width of the FIFO and engine data.
- TIMEOUT, 4096, maximum cycles to wait for eng_done before bypassing the engine.
- CNT_W, 16, width of frame_count.

Ports:
- clk  in  1  system clock (CLOCK_50 at top)
- reset  in  1  synchronous, active-high
- audio_in_available  in  1  ADC FIFO holds at least one L/R pair
- audio_out_allowed  in  1  DAC FIFO can accept one L/R pair
- left_in  in  DATA_W  ADC left sample, valid while audio_in_available=1
- right_in  in  DATA_W  ADC right sample, valid while audio_in_available=1
- read_audio_in  out  1  one-cycle ADC FIFO pop
- write_audio_out  out  1  one-cycle DAC FIFO push
- left_out  out  DATA_W  processed left sample, held between writes
- right_out  out  DATA_W  processed right sample, held between writes
- eng_start  out  1  one-cycle engine request
- eng_sel  out  1  engine channel context: 0=left, 1=right
- eng_data  out  DATA_W  sample presented to the engine, stable from eng_start until done or timeout
- eng_done  in  1  engine result valid this cycle
- eng_result  in  DATA_W  engine output
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky; set on any engine timeout
- frame_count  out  CNT_W  frames written, wraps modulo 2^CNT_W

Behaviour:
- Reset: state=IDLE. All outputs 0; internal latches and timeout counter 0. Reset asserted in any state aborts the frame with no write pulse.
- State register and data registers are clocked. read_audio_in, write_audio_out, eng_start and busy are Moore decodes of the registered state.
- FSM states: IDLE, READ, START_L, WAIT_L, START_R, WAIT_R, OUT_WAIT, WRITE.
- IDLE: when audio_in_available=1, latch left_in/right_in and go to READ. audio_out_allowed is not required to accept a frame.
- READ: read_audio_in=1 for exactly one cycle, then START_L.
- START_L: eng_start=1, eng_sel=0, eng_data=latched L; clear the timeout counter; go to WAIT_L.
- WAIT_L: eng_done is sampled only in WAIT states; an eng_done during a START state is ignored.
  - On eng_done=1, capture eng_result as res_L and go to START_R.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT-1, res_L=latched L (bypass), set timeout_err, go to START_R.
- START_R / WAIT_R: same as START_L / WAIT_L, with eng_sel=1 and the right sample; exit to OUT_WAIT.
- OUT_WAIT: if audio_out_allowed=1, load left_out=res_L and right_out=res_R, go to WRITE; otherwise hold indefinitely (no timeout).
- WRITE: write_audio_out=1 for one cycle; frame_count+1 (wraps to 0 after all-ones); go to IDLE.
- Minimum latency (accept cycle = 0, eng_done on first WAIT cycle, audio_out_allowed=1):
  - read pulse at cycle 1.
  - eng_start at cycles 2 and 4.
  - write pulse at cycle 7.
  - Next frame accepted at cycle 8 at the earliest.
- Never more than one frame in flight. read and write pulses never overlap.
- timeout_err clears only on reset.

Optional Feature:
- Macro MONO_SUM_EN.
- Defined:
  - START_L presents eng_data = (L+R) arithmetically shifted right by 1, with the sum computed at DATA_W+1 bits so it never overflows.
  - START_R/WAIT_R are skipped; WAIT_L exits to OUT_WAIT.
  - left_out = right_out = the engine result.
  - Minimum latency: write pulse at cycle 5.
- Undefined: independent L/R processing as above.

Test Plan:
- Single frame: avail=1, L=0x00001000, R=0xFFFFF000, engine returns input+1 one cycle after start. Required: one read pulse at cycle 1; eng_start at cycles 2 (sel=0) and 4 (sel=1); write pulse at cycle 7 with left_out=0x00001001, right_out=0xFFFFF001; frame_count=1.
- Backpressure: audio_out_allowed=0 for 50 cycles after results are ready. Required: FSM holds in OUT_WAIT, busy=1, no write pulse; write pulse on the cycle after allowed rises; outputs unchanged until then.
- Timeout: TIMEOUT=8, engine never asserts done, L=0x5, R=0x9. Required: timeout_err=1 after the first wait; outputs 0x5/0x9; write occurs; timeout_err remains 1 on the next clean frame.
- Reset mid-frame: assert reset during WAIT_R. Required: next cycle state=IDLE, all outputs 0, no write pulse; the next frame proceeds normally.
- Wrap: CNT_W=4, run 17 frames back-to-back. Required: frame_count=1; exactly 17 read and 17 write pulses, never overlapping.
- MONO_SUM_EN build: L=0x7FFFFFFF, R=0x7FFFFFFF, engine echoes input. Required: eng_data=0x7FFFFFFF; both outputs 0x7FFFFFFF; write pulse at cycle 5; eng_sel never 1.

Source files
------------

// File: rtl/audio_frame_scheduler.sv
// Moves one stereo frame from the ADC FIFO through a shared pitch-shift engine
// (left, then right) into the DAC FIFO. Define MONO_SUM_EN to process (L+R)/2 once.
module audio_frame_scheduler #(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 4096,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              audio_in_available,
   input  logic              audio_out_allowed,
   input  logic [DATA_W-1:0] left_in,
   input  logic [DATA_W-1:0] right_in,
   output logic              read_audio_in,
   output logic              write_audio_out,
   output logic [DATA_W-1:0] left_out,
   output logic [DATA_W-1:0] right_out,
   output logic              eng_start,
   output logic              eng_sel,
   output logic [DATA_W-1:0] eng_data,
   input  logic              eng_done,
   input  logic [DATA_W-1:0] eng_result,
   output logic              busy,
   output logic              timeout_err,
   output logic [CNT_W-1:0]  frame_count
);

   localparam int TCNT_W = $clog2(TIMEOUT + 1);
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      START_L,
      WAIT_L,
      START_R,
      WAIT_R,
      OUT_WAIT,
      WRITE
   } state_t;

   state_t state, state_next;

   logic [DATA_W-1:0] left_lat, right_lat, res_l;
   logic [TCNT_W-1:0] tcnt;
   logic              tcnt_hit;

   assign tcnt_hit = (tcnt == TCNT_LAST);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // A frame is accepted without regard to DAC space; backpressure is absorbed in OUT_WAIT.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (audio_in_available) state_next = READ;
         READ:     state_next = START_L;
         START_L:  state_next = WAIT_L;
`ifdef MONO_SUM_EN
         WAIT_L:   if (eng_done || tcnt_hit) state_next = OUT_WAIT;
`else
         WAIT_L:   if (eng_done || tcnt_hit) state_next = START_R;
`endif
         START_R:  state_next = WAIT_R;
         WAIT_R:   if (eng_done || tcnt_hit) state_next = OUT_WAIT;
         OUT_WAIT: if (audio_out_allowed) state_next = WRITE;
         WRITE:    state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   assign read_audio_in   = (state == READ);
   assign write_audio_out = (state == WRITE);
   assign eng_start       = (state == START_L) || (state == START_R);
   assign eng_sel         = (state == START_R) || (state == WAIT_R);
   assign busy            = (state != IDLE);

`ifdef MONO_SUM_EN
   // One extra bit keeps the sum of two full-scale samples exact before halving.
   logic [DATA_W:0] mono_sum;
   assign mono_sum = {left_lat[DATA_W-1], left_lat} + {right_lat[DATA_W-1], right_lat};
   assign eng_data = DATA_W'($signed(mono_sum) >>> 1);
`else
   logic [DATA_W-1:0] res_r;
   assign eng_data = eng_sel ? right_lat : left_lat;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         left_lat    <= '0;
         right_lat   <= '0;
         res_l       <= '0;
`ifndef MONO_SUM_EN
         res_r       <= '0;
`endif
         tcnt        <= '0;
         left_out    <= '0;
         right_out   <= '0;
         timeout_err <= 1'b0;
         frame_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (audio_in_available) begin
                  left_lat  <= left_in;
                  right_lat <= right_in;
               end
            end
            START_L, START_R: tcnt <= '0;
            // On timeout the untouched input sample is passed through instead.
            WAIT_L: begin
               if (eng_done) begin
                  res_l <= eng_result;
               end else if (tcnt_hit) begin
                  res_l       <= left_lat;
                  timeout_err <= 1'b1;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
`ifndef MONO_SUM_EN
            WAIT_R: begin
               if (eng_done) begin
                  res_r <= eng_result;
               end else if (tcnt_hit) begin
                  res_r       <= right_lat;
                  timeout_err <= 1'b1;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
`endif
            OUT_WAIT: begin
               if (audio_out_allowed) begin
                  left_out  <= res_l;
`ifdef MONO_SUM_EN
                  right_out <= res_l;
`else
                  right_out <= res_r;
`endif
               end
            end
            WRITE:   frame_count <= frame_count + 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_audio_frame_scheduler.sv
// Directed bench for audio_frame_scheduler: table of single frames plus hand-written
// backpressure, timeout, mid-frame reset and frame-counter wrap sequences.
module tb_audio_frame_scheduler;

   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 8;
   localparam int CNT_W   = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              audio_in_available;
   logic              audio_out_allowed;
   logic [DATA_W-1:0] left_in, right_in;
   logic              read_audio_in, write_audio_out;
   logic [DATA_W-1:0] left_out, right_out;
   logic              eng_start, eng_sel;
   logic [DATA_W-1:0] eng_data;
   logic              eng_done;
   logic [DATA_W-1:0] eng_result;
   logic              busy, timeout_err;
   logic [CNT_W-1:0]  frame_count;

   int checks = 0;
   int passes = 0;

   logic              eng_enable;
   logic [DATA_W-1:0] eng_delta;
   logic [CNT_W-1:0]  exp_fc;

   int read_total    = 0;
   int write_total   = 0;
   int overlap_total = 0;
   logic sel1_seen   = 1'b0;

   typedef struct {
      logic [DATA_W-1:0] l, r, delta, exp_eng, exp_left, exp_right;
   } vec_t;

   typedef struct {
      int read_cyc, read_n, start_n, write_cyc, write_n;
      int start_cyc0, start_cyc1;
      logic sel0, sel1, err;
      logic [DATA_W-1:0] data0, data1, out_l, out_r;
      logic [CNT_W-1:0] fc;
   } obs_t;

   vec_t vecs[4];

   audio_frame_scheduler #(
      .DATA_W(DATA_W),
      .TIMEOUT(TIMEOUT),
      .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .audio_in_available(audio_in_available),
      .audio_out_allowed(audio_out_allowed),
      .left_in(left_in),
      .right_in(right_in),
      .read_audio_in(read_audio_in),
      .write_audio_out(write_audio_out),
      .left_out(left_out),
      .right_out(right_out),
      .eng_start(eng_start),
      .eng_sel(eng_sel),
      .eng_data(eng_data),
      .eng_done(eng_done),
      .eng_result(eng_result),
      .busy(busy),
      .timeout_err(timeout_err),
      .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   // Engine model: answers input+delta one cycle after a start, or never when disabled.
   always @(posedge clk) begin
      if (reset) begin
         eng_done   <= 1'b0;
         eng_result <= '0;
      end else begin
         eng_done   <= eng_enable && eng_start;
         eng_result <= eng_data + eng_delta;
      end
   end

   always @(negedge clk) begin
      if (read_audio_in) read_total++;
      if (write_audio_out) write_total++;
      if (read_audio_in && write_audio_out) overlap_total++;
      if (eng_sel) sel1_seen = 1'b1;
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
   endtask

   // Called at a negedge while the DUT is idle; returns at the first negedge back in IDLE.
   task automatic applyStimulus(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r, output obs_t o);
      logic got;
      o.read_cyc = -1; o.read_n = 0; o.start_n = 0; o.write_cyc = -1; o.write_n = 0;
      o.start_cyc0 = -1; o.start_cyc1 = -1;
      o.sel0 = 1'bx; o.sel1 = 1'bx; o.err = 1'bx;
      o.data0 = 'x; o.data1 = 'x; o.out_l = 'x; o.out_r = 'x; o.fc = 'x;
      got = 1'b0;
      audio_in_available = 1'b1;
      left_in  = l;
      right_in = r;
      for (int c = 1; c <= 40 && !got; c++) begin
         @(negedge clk);
         if (c == 1) audio_in_available = 1'b0;
         if (read_audio_in) begin
            o.read_n++;
            if (o.read_cyc < 0) o.read_cyc = c;
         end
         if (eng_start) begin
            if (o.start_n == 0) begin
               o.start_cyc0 = c; o.sel0 = eng_sel; o.data0 = eng_data;
            end else if (o.start_n == 1) begin
               o.start_cyc1 = c; o.sel1 = eng_sel; o.data1 = eng_data;
            end
            o.start_n++;
         end
         if (write_audio_out) begin
            o.write_n++;
            o.write_cyc = c;
            o.out_l = left_out;
            o.out_r = right_out;
            o.err   = timeout_err;
            got     = 1'b1;
         end
      end
      @(negedge clk);
      o.fc = frame_count;
   endtask

   initial begin
      obs_t o;
      int   rd0, wr0, bad;
      logic [DATA_W-1:0] bp_l, bp_r;

      reset = 1'b1;
      audio_in_available = 1'b0;
      audio_out_allowed  = 1'b0;
      left_in = '0; right_in = '0;
      eng_enable = 1'b0; eng_delta = '0;
      exp_fc = '0;

`ifdef MONO_SUM_EN
      vecs[0] = '{32'h00001000, 32'hFFFFF000, 32'd1, 32'h00000000, 32'h00000001, 32'h00000001};
      vecs[1] = '{32'h00000000, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
      vecs[2] = '{32'h12345678, 32'h7FFFFFFF, 32'd1, 32'h491A2B3B, 32'h491A2B3C, 32'h491A2B3C};
      vecs[3] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF};
`else
      vecs[0] = '{32'h00001000, 32'hFFFFF000, 32'd1, 32'h00001000, 32'h00001001, 32'hFFFFF001};
      vecs[1] = '{32'h00000000, 32'hFFFFFFFF, 32'd1, 32'h00000000, 32'h00000001, 32'h00000000};
      vecs[2] = '{32'h12345678, 32'h7FFFFFFF, 32'd1, 32'h12345678, 32'h12345679, 32'h80000000};
      vecs[3] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF};
`endif

      repeat (3) @(negedge clk);
      checkOutput("rst_read", read_audio_in, 0);
      checkOutput("rst_write", write_audio_out, 0);
      checkOutput("rst_start", eng_start, 0);
      checkOutput("rst_sel", eng_sel, 0);
      checkOutput("rst_eng_data", eng_data, 0);
      checkOutput("rst_left_out", left_out, 0);
      checkOutput("rst_right_out", right_out, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_timeout_err", timeout_err, 0);
      checkOutput("rst_frame_count", frame_count, 0);
      reset = 1'b0;
      @(negedge clk);

      // Table of single frames at minimum latency.
      audio_out_allowed = 1'b1;
      eng_enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         eng_delta = vecs[i].delta;
         applyStimulus(vecs[i].l, vecs[i].r, o);
         exp_fc++;
         checkOutput("read_cycle", o.read_cyc, 1);
         checkOutput("read_count", o.read_n, 1);
         checkOutput("start_l_cycle", o.start_cyc0, 2);
         checkOutput("start_l_sel", o.sel0, 0);
         checkOutput("start_l_data", o.data0, vecs[i].exp_eng);
`ifdef MONO_SUM_EN
         checkOutput("start_count", o.start_n, 1);
         checkOutput("write_cycle", o.write_cyc, 5);
`else
         checkOutput("start_count", o.start_n, 2);
         checkOutput("start_r_cycle", o.start_cyc1, 4);
         checkOutput("start_r_sel", o.sel1, 1);
         checkOutput("start_r_data", o.data1, vecs[i].r);
         checkOutput("write_cycle", o.write_cyc, 7);
`endif
         checkOutput("write_count", o.write_n, 1);
         checkOutput("left_out", o.out_l, vecs[i].exp_left);
         checkOutput("right_out", o.out_r, vecs[i].exp_right);
         checkOutput("frame_count", o.fc, exp_fc);
      end

      // Backpressure: DAC refuses for 50 cycles once results are ready.
      eng_delta = 32'd1;
      audio_out_allowed = 1'b0;
      audio_in_available = 1'b1;
      left_in = 32'hA0A0A0A0; right_in = 32'h0B0B0B0B;
`ifdef MONO_SUM_EN
      bp_l = 32'hD5D5D5D6; bp_r = 32'hD5D5D5D6;
`else
      bp_l = 32'hA0A0A0A1; bp_r = 32'h0B0B0B0C;
`endif
      @(negedge clk);
      audio_in_available = 1'b0;
      repeat (5) @(negedge clk);
      bad = 0;
      for (int k = 0; k < 50; k++) begin
         if (busy !== 1'b1 || write_audio_out !== 1'b0 ||
             left_out !== 32'h7FFFFFFF || right_out !== 32'h7FFFFFFF) bad++;
         @(negedge clk);
      end
      checkOutput("bp_hold_violations", bad, 0);
      audio_out_allowed = 1'b1;
      @(negedge clk);
      checkOutput("bp_write_after_allow", write_audio_out, 1);
      checkOutput("bp_left_out", left_out, bp_l);
      checkOutput("bp_right_out", right_out, bp_r);
      @(negedge clk);
      exp_fc++;
      checkOutput("bp_busy_after", busy, 0);
      checkOutput("bp_frame_count", frame_count, exp_fc);

      // Engine never answers: both channels bypass, error flag becomes sticky.
      eng_enable = 1'b0;
      applyStimulus(32'h5, 32'h9, o);
      exp_fc++;
      checkOutput("to_write_count", o.write_n, 1);
      checkOutput("to_err", o.err, 1);
      checkOutput("to_left_out", o.out_l, 32'h5);
`ifdef MONO_SUM_EN
      checkOutput("to_right_out", o.out_r, 32'h5);
`else
      checkOutput("to_right_out", o.out_r, 32'h9);
`endif
      checkOutput("to_frame_count", o.fc, exp_fc);
      eng_enable = 1'b1;
      applyStimulus(32'h100, 32'h200, o);
      exp_fc++;
      checkOutput("to_clean_err_sticky", o.err, 1);
`ifdef MONO_SUM_EN
      checkOutput("to_clean_left", o.out_l, 32'h181);
      checkOutput("to_clean_right", o.out_r, 32'h181);
`else
      checkOutput("to_clean_left", o.out_l, 32'h101);
      checkOutput("to_clean_right", o.out_r, 32'h201);
`endif

      // Reset in the middle of a frame (second wait state, or the only one in mono).
`ifdef MONO_SUM_EN
      eng_enable = 1'b0;
`endif
      audio_in_available = 1'b1;
      left_in = 32'h11; right_in = 32'h22;
      wr0 = 0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         audio_in_available = 1'b0;
         if (write_audio_out) wr0++;
      end
      checkOutput("mid_busy_before_reset", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_fc = '0;
      checkOutput("mid_busy", busy, 0);
      checkOutput("mid_write", write_audio_out, 0);
      checkOutput("mid_start", eng_start, 0);
      checkOutput("mid_left_out", left_out, 0);
      checkOutput("mid_right_out", right_out, 0);
      checkOutput("mid_eng_data", eng_data, 0);
      checkOutput("mid_timeout_err", timeout_err, 0);
      checkOutput("mid_frame_count", frame_count, 0);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (write_audio_out) wr0++;
      end
      checkOutput("mid_no_write", wr0, 0);
      eng_enable = 1'b1;
      eng_delta  = 32'd1;
      applyStimulus(32'h11, 32'h22, o);
      exp_fc++;
`ifdef MONO_SUM_EN
      checkOutput("mid_next_write_cycle", o.write_cyc, 5);
      checkOutput("mid_next_left", o.out_l, 32'h1A);
      checkOutput("mid_next_right", o.out_r, 32'h1A);
`else
      checkOutput("mid_next_write_cycle", o.write_cyc, 7);
      checkOutput("mid_next_left", o.out_l, 32'h12);
      checkOutput("mid_next_right", o.out_r, 32'h23);
`endif
      checkOutput("mid_next_err", o.err, 0);
      checkOutput("mid_next_frame_count", o.fc, exp_fc);

      // Counter wrap: 17 back-to-back frames from a fresh reset.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      rd0 = read_total;
      wr0 = write_total;
      for (int i = 0; i < 17; i++) applyStimulus(DATA_W'(i), DATA_W'(i + 100), o);
      checkOutput("wrap_frame_count", frame_count, 1);
      checkOutput("wrap_reads", read_total - rd0, 17);
      checkOutput("wrap_writes", write_total - wr0, 17);
      checkOutput("wrap_overlaps", overlap_total, 0);
      checkOutput("wrap_last_read_cycle", o.read_cyc, 1);

`ifdef MONO_SUM_EN
      checkOutput("sel_right_seen", sel1_seen, 0);
`else
      checkOutput("sel_right_seen", sel1_seen, 1);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
